// File: rtl/ahb_mux_param.sv
// rtl/ahb_mux_param.sv - AHB-Lite address decoder, slave response mux and built-in default error slave.
// Optional wait-state watchdog enabled by defining AHB_MUX_TIMEOUT_EN.
module ahb_mux_param #(
    parameter int                 NSLV        = 2,
    parameter logic [NSLV*32-1:0] SLV_BASE    = {32'h0002_0000, 32'h0000_0000},
    parameter logic [NSLV*32-1:0] SLV_MASK    = {32'hFFFF_FFF0, 32'hFFFF_0000},
    parameter int                 TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          m_haddr,
    input  logic [1:0]           m_htrans,
    input  logic                 m_hwrite,
    input  logic [2:0]           m_hsize,
    input  logic [2:0]           m_hburst,
    input  logic [31:0]          m_hwdata,
    output logic [31:0]          m_hrdata,
    output logic                 m_hready,
    output logic                 m_hresp,
    output logic [NSLV-1:0]      s_hsel,
    output logic [31:0]          s_haddr,
    output logic [1:0]           s_htrans,
    output logic                 s_hwrite,
    output logic [2:0]           s_hsize,
    output logic [2:0]           s_hburst,
    output logic [31:0]          s_hwdata,
    output logic                 s_hready,
    input  logic [NSLV*32-1:0]   s_hrdata,
    input  logic [NSLV-1:0]      s_hreadyout,
    input  logic [NSLV-1:0]      s_hresp,
    output logic                 timeout_irq
);

    localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {SEL_NONE, SEL_DS, SEL_SLV} sel_e;
    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

    sel_e            dsel;
    logic [IDXW-1:0] dsel_idx;
    ds_state_e       ds_state, ds_next;

    logic            active, dec_hit, dec_ds;
    logic [IDXW-1:0] dec_idx;
    logic [31:0]     slv_rdata;
    logic            slv_ready, slv_resp;
    logic            stall;

    assign s_haddr  = m_haddr;
    assign s_htrans = m_htrans;
    assign s_hwrite = m_hwrite;
    assign s_hsize  = m_hsize;
    assign s_hburst = m_hburst;
    assign s_hwdata = m_hwdata;
    assign s_hready = m_hready;

    assign active = m_htrans[1];
    assign dec_ds = active && !dec_hit;

    // Descending scan so the lowest matching slot wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((m_haddr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                dec_hit = 1'b1;
                dec_idx = IDXW'(i);
            end
        end
        s_hsel = '0;
        for (int i = 0; i < NSLV; i++) begin
            s_hsel[i] = active && dec_hit && (dec_idx == IDXW'(i));
        end
    end

    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (dsel_idx == IDXW'(i)) begin
                slv_rdata = s_hrdata[32*i +: 32];
                slv_ready = s_hreadyout[i];
                slv_resp  = s_hresp[i];
            end
        end
    end

    // Error sequencing overrides whatever dsel points at (default slave or watchdog abort).
    always_comb begin
        m_hrdata = '0;
        m_hready = 1'b1;
        m_hresp  = 1'b0;
        case (ds_state)
            DS_ERR1: begin
                m_hready = 1'b0;
                m_hresp  = 1'b1;
            end
            DS_ERR2: begin
                m_hresp  = 1'b1;
            end
            default: begin
                if (dsel == SEL_SLV) begin
                    m_hrdata = slv_rdata;
                    m_hready = slv_ready;
                    m_hresp  = slv_resp;
                end
            end
        endcase
    end

    assign stall = (ds_state == DS_IDLE) && (dsel == SEL_SLV) && !slv_ready;

`ifdef AHB_MUX_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYC + 1);

    logic [CNTW-1:0] wd_cnt;
    logic            wd_fire;

    assign wd_fire = stall && (wd_cnt == CNTW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            timeout_irq <= 1'b0;
        end else begin
            timeout_irq <= wd_fire;
            if (stall && !wd_fire) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`else
    logic wd_fire;

    assign wd_fire     = 1'b0;
    assign timeout_irq = 1'b0;
`endif

    always_comb begin
        ds_next = DS_IDLE;
        if (ds_state == DS_ERR1) begin
            ds_next = DS_ERR2;
        end else if ((m_hready && dec_ds) || wd_fire) begin
            ds_next = DS_ERR1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ds_state <= DS_IDLE;
            dsel     <= SEL_NONE;
            dsel_idx <= '0;
        end else begin
            ds_state <= ds_next;
            if (m_hready) begin
                dsel     <= !active ? SEL_NONE : (dec_hit ? SEL_SLV : SEL_DS);
                dsel_idx <= dec_idx;
            end
        end
    end

endmodule

// File: tb/tb_ahb_mux_param.sv
// tb/tb_ahb_mux_param.sv - self-checking bench for ahb_mux_param: directed scenarios plus randomized traffic against a reference model.
module tb_ahb_mux_param;

    localparam int T_CYC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_haddr, m_hwdata, m_hrdata;
    logic [1:0]  m_htrans;
    logic        m_hwrite, m_hready, m_hresp;
    logic [2:0]  m_hsize, m_hburst;
    logic [1:0]  s_hsel;
    logic [31:0] s_haddr, s_hwdata;
    logic [1:0]  s_htrans;
    logic        s_hwrite, s_hready;
    logic [2:0]  s_hsize, s_hburst;
    logic [63:0] s_hrdata;
    logic [1:0]  s_hreadyout, s_hresp;
    logic        timeout_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_mux_param #(.TIMEOUT_CYC(T_CYC)) dut (
        .clk(clk), .rst(rst),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hwdata(s_hwdata), .s_hready(s_hready),
        .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
        .timeout_irq(timeout_irq)
    );

    // Address map of the bench's view of the system: slot 0 RAM 0x0000_xxxx, slot 1 UART 0x0002_000x.
    function automatic int ref_decode(input logic [31:0] a);
        logic [31:0] base [2];
        logic [31:0] mask [2];
        base[0] = 32'h0000_0000; mask[0] = 32'hFFFF_0000;
        base[1] = 32'h0002_0000; mask[1] = 32'hFFFF_FFF0;
        for (int i = 0; i < 2; i++) if ((a & mask[i]) == base[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_htrans = 2'd0;
        s_hreadyout = 2'b11;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_htrans = 2'd0;
        s_hreadyout = 2'b00;
        s_hresp = 2'b11;
        s_hrdata = {32'h1111_1111, 32'h2222_2222};
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (m_hready !== 1'b1) begin errors++; $display("FAIL rst_hready got %b exp 1", m_hready); end
        checks++; if (m_hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp got %b exp 0", m_hresp); end
        checks++; if (m_hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", m_hrdata); end
        checks++; if (s_hready !== 1'b1) begin errors++; $display("FAIL rst_s_hready got %b exp 1", s_hready); end
        checks++; if (timeout_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", timeout_irq); end
        checks++; if (s_hsel !== 2'b00) begin errors++; $display("FAIL rst_hsel got %b exp 00", s_hsel); end
        tick();
        s_hresp = 2'b00;
    endtask

    task automatic test_read_ram();
        m_htrans = 2'd2; m_hwrite = 1'b0; m_haddr = 32'h0000_0040;
        s_hreadyout = 2'b11;
        @(negedge clk);
        checks++; if (s_hsel !== 2'b01) begin errors++; $display("FAIL t1_hsel got %b exp 01", s_hsel); end
        tick();
        m_htrans = 2'd0; s_hreadyout = 2'b10;
        @(negedge clk);
        checks++; if (m_hready !== 1'b0) begin errors++; $display("FAIL t1_wait got %b exp 0", m_hready); end
        tick();
        s_hreadyout = 2'b11; s_hrdata = {32'h5555_5555, 32'hDEAD_BEEF};
        @(negedge clk);
        checks++; if (m_hready !== 1'b1) begin errors++; $display("FAIL t1_ready got %b exp 1", m_hready); end
        checks++; if (m_hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_rdata got %h exp deadbeef", m_hrdata); end
        checks++; if (m_hresp !== 1'b0) begin errors++; $display("FAIL t1_resp got %b exp 0", m_hresp); end
        tick();
    endtask

    task automatic test_write_uart();
        m_htrans = 2'd2; m_hwrite = 1'b1; m_haddr = 32'h0002_0008;
        @(negedge clk);
        checks++; if (s_hsel !== 2'b10) begin errors++; $display("FAIL t2_hsel got %b exp 10", s_hsel); end
        tick();
        m_htrans = 2'd0; m_hwdata = 32'hA5A5_0001; s_hreadyout = 2'b01;
        @(negedge clk);
        checks++; if (m_hready !== 1'b0) begin errors++; $display("FAIL t2_wait got %b exp 0", m_hready); end
        checks++; if (s_hwdata !== 32'hA5A5_0001) begin errors++; $display("FAIL t2_hwdata got %h exp a5a50001", s_hwdata); end
        tick();
        s_hreadyout = 2'b11;
        @(negedge clk);
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin errors++; $display("FAIL t2_done got rdy %b resp %b exp 1 0", m_hready, m_hresp); end
        tick();
    endtask

    task automatic test_unmapped();
        m_htrans = 2'd2; m_hwrite = 1'b0; m_haddr = 32'h0003_0000;
        @(negedge clk);
        checks++; if (s_hsel !== 2'b00) begin errors++; $display("FAIL t3_hsel got %b exp 00", s_hsel); end
        tick();
        m_htrans = 2'd0;
        @(negedge clk);
        checks++; if (m_hready !== 1'b0 || m_hresp !== 1'b1) begin errors++; $display("FAIL t3_err1 got rdy %b resp %b exp 0 1", m_hready, m_hresp); end
        tick();
        @(negedge clk);
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b1) begin errors++; $display("FAIL t3_err2 got rdy %b resp %b exp 1 1", m_hready, m_hresp); end
        tick();
        @(negedge clk);
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin errors++; $display("FAIL t3_after got rdy %b resp %b exp 1 0", m_hready, m_hresp); end
        tick();
    endtask

    task automatic test_pipelined();
        s_hreadyout = 2'b11;
        s_hrdata = {32'h0BAD_CAFE, 32'h1234_ABCD};
        m_htrans = 2'd2; m_haddr = 32'h0000_0100;
        tick();
        m_haddr = 32'h0002_0004;
        @(negedge clk);
        checks++; if (m_hrdata !== 32'h1234_ABCD || m_hready !== 1'b1) begin errors++; $display("FAIL t4_ram got %h rdy %b exp 1234abcd 1", m_hrdata, m_hready); end
        checks++; if (s_hsel !== 2'b10) begin errors++; $display("FAIL t4_hsel got %b exp 10", s_hsel); end
        tick();
        m_htrans = 2'd0;
        @(negedge clk);
        checks++; if (m_hrdata !== 32'h0BAD_CAFE || m_hready !== 1'b1) begin errors++; $display("FAIL t4_uart got %h rdy %b exp 0badcafe 1", m_hrdata, m_hready); end
        tick();
        s_hreadyout = 2'b00; s_hresp = 2'b11;
        @(negedge clk);
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0 || m_hrdata !== 32'h0) begin errors++; $display("FAIL t4_idle got rdy %b resp %b data %h exp 1 0 0", m_hready, m_hresp, m_hrdata); end
        tick();
        s_hreadyout = 2'b11; s_hresp = 2'b00;
    endtask

    task automatic test_mid_reset();
        m_htrans = 2'd2; m_haddr = 32'h0000_0080;
        tick();
        m_htrans = 2'd0; s_hreadyout = 2'b10; rst = 1'b1;
        s_hrdata = {32'h0, 32'h1234_5678};
        @(negedge clk);
        checks++; if (m_hready !== 1'b0) begin errors++; $display("FAIL t5_stall got %b exp 0", m_hready); end
        tick();
        rst = 1'b0; m_htrans = 2'd2; m_haddr = 32'h0002_0000;
        @(negedge clk);
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0 || m_hrdata !== 32'h0) begin errors++; $display("FAIL t5_after got rdy %b resp %b data %h exp 1 0 0", m_hready, m_hresp, m_hrdata); end
        checks++; if (s_hsel !== 2'b10) begin errors++; $display("FAIL t5_hsel got %b exp 10", s_hsel); end
        tick();
        m_htrans = 2'd0; s_hreadyout = 2'b11; s_hrdata = {32'hCAFE_F00D, 32'h1234_5678};
        @(negedge clk);
        checks++; if (m_hrdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL t5_rdata got %h exp cafef00d", m_hrdata); end
        tick();
    endtask

    task automatic test_watchdog();
        m_htrans = 2'd2; m_haddr = 32'h0000_0010; s_hreadyout = 2'b11; s_hresp = 2'b00;
        tick();
        m_htrans = 2'd0; s_hreadyout = 2'b10;
`ifdef AHB_MUX_TIMEOUT_EN
        for (int c = 0; c < T_CYC; c++) begin
            @(negedge clk);
            checks++; if (m_hready !== 1'b0 || m_hresp !== 1'b0 || timeout_irq !== 1'b0) begin errors++; $display("FAIL t6_wait%0d got rdy %b resp %b irq %b exp 0 0 0", c, m_hready, m_hresp, timeout_irq); end
            tick();
        end
        @(negedge clk);
        checks++; if (m_hready !== 1'b0 || m_hresp !== 1'b1 || timeout_irq !== 1'b1) begin errors++; $display("FAIL t6_err1 got rdy %b resp %b irq %b exp 0 1 1", m_hready, m_hresp, timeout_irq); end
        tick();
        @(negedge clk);
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b1 || timeout_irq !== 1'b0) begin errors++; $display("FAIL t6_err2 got rdy %b resp %b irq %b exp 1 1 0", m_hready, m_hresp, timeout_irq); end
        tick();
        @(negedge clk);
        checks++; if (m_hready !== 1'b1 || m_hresp !== 1'b0) begin errors++; $display("FAIL t6_after got rdy %b resp %b exp 1 0", m_hready, m_hresp); end
        tick();
`else
        for (int c = 0; c < 5 * T_CYC; c++) begin
            @(negedge clk);
            checks++; if (m_hready !== 1'b0 || timeout_irq !== 1'b0) begin errors++; $display("FAIL t6_stall%0d got rdy %b irq %b exp 0 0", c, m_hready, timeout_irq); end
            tick();
        end
`endif
        do_reset();
    endtask

    // Model: the data phase is either idle, a slave slot, or a pending error with 2 or 1 cycles left.
    task automatic test_random();
        int dp_slot = -1;
        int err_left = 0;
        int stall_run [2] = '{0, 0};
        int dec;
        logic exp_ready, exp_resp;
        logic [31:0] exp_rdata;
        logic [1:0] exp_hsel;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            m_htrans = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: m_haddr = {16'h0000, 16'($urandom)};
                1: m_haddr = 32'h0002_0000 | 32'($urandom_range(0, 15));
                2: m_haddr = 32'h0003_0000 | 32'($urandom_range(0, 65535));
                default: m_haddr = $urandom;
            endcase
            m_hwrite = 1'($urandom); m_hwdata = $urandom;
            m_hsize = 3'($urandom); m_hburst = 3'($urandom);
            s_hrdata = {$urandom, $urandom};
            s_hresp = 2'($urandom_range(0, 3) == 0 ? 2'b11 : 2'b00);
            for (int i = 0; i < 2; i++)
                s_hreadyout[i] = (stall_run[i] >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
            dec = m_htrans[1] ? ref_decode(m_haddr) : -2;
            exp_hsel = (dec >= 0) ? 2'(1 << dec) : 2'b00;
            if (err_left == 2) begin exp_ready = 0; exp_resp = 1; exp_rdata = 0; end
            else if (err_left == 1) begin exp_ready = 1; exp_resp = 1; exp_rdata = 0; end
            else if (dp_slot >= 0) begin
                exp_ready = s_hreadyout[dp_slot]; exp_resp = s_hresp[dp_slot];
                exp_rdata = s_hrdata[32*dp_slot +: 32];
            end else begin exp_ready = 1; exp_resp = 0; exp_rdata = 0; end
            @(negedge clk);
            checks++; if (m_hready !== exp_ready || s_hready !== exp_ready) begin errors++; $display("FAIL rnd%0d_ready got %b/%b exp %b", n, m_hready, s_hready, exp_ready); end
            checks++; if (m_hresp !== exp_resp) begin errors++; $display("FAIL rnd%0d_resp got %b exp %b", n, m_hresp, exp_resp); end
            checks++; if (m_hrdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, m_hrdata, exp_rdata); end
            checks++; if (s_hsel !== exp_hsel) begin errors++; $display("FAIL rnd%0d_hsel got %b exp %b", n, s_hsel, exp_hsel); end
            checks++; if (s_haddr !== m_haddr || s_htrans !== m_htrans || s_hwrite !== m_hwrite || s_hsize !== m_hsize || s_hburst !== m_hburst) begin errors++; $display("FAIL rnd%0d_bcast got %h exp %h", n, s_haddr, m_haddr); end
            for (int i = 0; i < 2; i++) stall_run[i] = s_hreadyout[i] ? 0 : stall_run[i] + 1;
            if (err_left > 0) err_left--;
            if (exp_ready) begin
                if (dec == -1) begin dp_slot = -1; err_left = 2; end
                else dp_slot = (dec >= 0) ? dec : -1;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        m_haddr = '0; m_htrans = 2'd0; m_hwrite = 1'b0; m_hsize = 3'd2; m_hburst = 3'd0; m_hwdata = '0;
        s_hrdata = '0; s_hreadyout = 2'b11; s_hresp = 2'b00;
        tick();
        test_reset();
        test_read_ram();
        test_write_uart();
        test_unmapped();
        test_pipelined();
        test_mid_reset();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
